// File: rtl/present_core_param.sv
// present_core_param: iterative PRESENT-80/128 encrypt/decrypt core with on-the-fly
// round keys and a cached last-round key for repeated decrypts under one key.
module present_core_param #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [KEY_W-1:0] key,
    input  logic [63:0]      din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      dout,
    output logic             busy,
    output logic             cache_hit
);
    localparam int CW = $clog2(ROUNDS + 2);
    localparam logic [63:0] SB  = 64'h21748FE3DA09B65C;
    localparam logic [63:0] ISB = 64'hA970364BD21C8FE5;

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_core_param: KEY_W must be 80 or 128");
    end

    typedef enum logic [2:0] {IDLE, KFWD, ROUND, FINAL, DONE} state_t;

    function automatic logic [3:0] f_sb(input logic [3:0] x);
        return SB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] f_isb(input logic [3:0] x);
        return ISB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [KEY_W-1:0] f_kfwd(input logic [KEY_W-1:0] k, input logic [4:0] i);
        logic [KEY_W-1:0] t;
        t = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
        t[KEY_W-1 -: 4] = f_sb(t[KEY_W-1 -: 4]);
        if (KEY_W == 128) begin
            t[KEY_W-5 -: 4] = f_sb(t[KEY_W-5 -: 4]);
            t[66:62] = t[66:62] ^ i;
        end else begin
            t[19:15] = t[19:15] ^ i;
        end
        return t;
    endfunction

    // Exact inverse of f_kfwd for the same round index: K(i+1) -> K(i).
    function automatic logic [KEY_W-1:0] f_kinv(input logic [KEY_W-1:0] k, input logic [4:0] i);
        logic [KEY_W-1:0] t;
        t = k;
        if (KEY_W == 128) begin
            t[66:62] = t[66:62] ^ i;
            t[KEY_W-5 -: 4] = f_isb(t[KEY_W-5 -: 4]);
        end else begin
            t[19:15] = t[19:15] ^ i;
        end
        t[KEY_W-1 -: 4] = f_isb(t[KEY_W-1 -: 4]);
        return {t[60:0], t[KEY_W-1:61]};
    endfunction

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic [63:0]      r_st;
    logic [KEY_W-1:0] r_key;
    logic [KEY_W-1:0] r_orig;
    logic [KEY_W-1:0] r_ckey;
    logic [KEY_W-1:0] r_ck32;
    logic             r_cvalid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [63:0]      r_dout;
    logic             r_busy;
    logic             r_hit;

    logic [4:0]       w_rc;
    logic [63:0]      w_rk;
    logic [63:0]      w_x;
    logic [63:0]      w_sx;
    logic [63:0]      w_enc;
    logic [63:0]      w_ip;
    logic [63:0]      w_dec;
    logic [KEY_W-1:0] w_kf;
    logic [KEY_W-1:0] w_ki;
    logic             w_last;
    logic             w_hit;

    assign w_rc   = 5'(r_cnt);
    assign w_rk   = r_key[KEY_W-1 -: 64];
    assign w_x    = r_st ^ w_rk;
    assign w_kf   = f_kfwd(r_key, w_rc);
    assign w_ki   = f_kinv(r_key, w_rc);
    assign w_last = r_cnt == CW'(ROUNDS);
    assign w_hit  = mode && r_cvalid && key == r_ckey;

    // Encrypt: sbox then pLayer; decrypt: inverse pLayer then inverse sbox.
    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign w_sx[4*n +: 4]  = f_sb(w_x[4*n +: 4]);
        assign w_dec[4*n +: 4] = f_isb(w_ip[4*n +: 4]);
    end
    for (genvar j = 0; j < 63; j++) begin : g_perm
        assign w_enc[(16*j) % 63] = w_sx[j];
        assign w_ip[j]            = w_x[(16*j) % 63];
    end
    assign w_enc[63] = w_sx[63];
    assign w_ip[63]  = w_x[63];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_busy      <= 1'b0;
            r_hit       <= 1'b0;
            r_cvalid    <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_st       <= din;
                    r_mode     <= mode;
                    r_orig     <= key;
                    r_key      <= w_hit ? r_ck32 : key;
                    r_hit      <= w_hit;
                    r_cnt      <= w_hit ? CW'(ROUNDS) : CW'(1);
                    r_state    <= (mode && !w_hit) ? KFWD : ROUND;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
                KFWD: begin
                    r_key <= w_kf;
                    if (w_last) begin
                        r_ckey   <= r_orig;
                        r_ck32   <= w_kf;
                        r_cvalid <= 1'b1;
                        r_state  <= ROUND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ROUND: begin
                    r_st  <= r_mode ? w_dec : w_enc;
                    r_key <= r_mode ? w_ki : w_kf;
                    if (r_mode ? r_cnt == CW'(1) : w_last)
                        r_state <= FINAL;
                    else
                        r_cnt <= r_mode ? r_cnt - 1'b1 : r_cnt + 1'b1;
                end
                FINAL: begin
                    r_dout      <= w_x;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign busy      = r_busy;
    assign cache_hit = r_hit;
endmodule

// File: tb/tb_present_core_param.sv
// tb_present_core_param: scoreboard bench for 80- and 128-bit PRESENT core instances.
module tb_present_core_param;
    localparam logic [127:0] K80F = {48'h0, {80{1'b1}}};
    localparam logic [63:0]  ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv80 = 1'b0, iv128 = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [127:0] key = '0;
    logic [63:0] din = '0;
    logic ir80, ov80, busy80, hit80, ir128, ov128, busy128, hit128;
    logic [63:0] dout80, dout128;
    logic sel = 1'b0;
    logic ov_s, ir_s, busy_s, hit_s;
    logic [63:0] dout_s;
    logic [63:0] q_exp [$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    present_core_param #(.KEY_W(80), .ROUNDS(31)) u_dut80 (
        .clk(clk), .rst(rst), .in_valid(iv80), .in_ready(ir80), .mode(mode), .key(key[79:0]),
        .din(din), .out_valid(ov80), .out_ready(out_ready), .dout(dout80), .busy(busy80),
        .cache_hit(hit80));
    present_core_param #(.KEY_W(128), .ROUNDS(31)) u_dut128 (
        .clk(clk), .rst(rst), .in_valid(iv128), .in_ready(ir128), .mode(mode), .key(key),
        .din(din), .out_valid(ov128), .out_ready(out_ready), .dout(dout128), .busy(busy128),
        .cache_hit(hit128));

    assign ov_s   = sel ? ov128 : ov80;
    assign ir_s   = sel ? ir128 : ir80;
    assign busy_s = sel ? busy128 : busy80;
    assign hit_s  = sel ? hit128 : hit80;
    assign dout_s = sel ? dout128 : dout80;

    // Reference model: textbook PRESENT with the pLayer written as P(j) = 16*(j%4) + j/4.
    function automatic logic [127:0] m_step(input bit w, input logic [127:0] k, input int r);
        logic [127:0] t;
        logic [4:0] rc;
        rc = 5'(r);
        if (w) begin
            t = {k[66:0], k[127:67]};
            t[127:124] = SBOX[t[127:124]];
            t[123:120] = SBOX[t[123:120]];
            t[66:62] = t[66:62] ^ rc;
        end else begin
            t = {48'h0, k[18:0], k[79:19]};
            t[79:76] = SBOX[t[79:76]];
            t[19:15] = t[19:15] ^ rc;
        end
        return t;
    endfunction

    function automatic logic [63:0] m_top(input bit w, input logic [127:0] k);
        return w ? k[127:64] : k[79:16];
    endfunction

    function automatic logic [63:0] m_enc(input bit w, input logic [127:0] k0, input logic [63:0] p);
        logic [63:0] s, t, o;
        logic [127:0] k;
        s = p;
        k = k0;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ m_top(w, k);
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SBOX[s[4*n +: 4]];
            for (int j = 0; j < 64; j++) o[16*(j%4) + j/4] = t[j];
            s = o;
            k = m_step(w, k, r);
        end
        return s ^ m_top(w, k);
    endfunction

    task automatic send(input bit w, input bit m, input logic [127:0] k, input logic [63:0] d,
                        input logic [63:0] e);
        sel = w;
        mode = m;
        key = k;
        din = d;
        q_exp.push_back(e);
        if (w) iv128 = 1'b1; else iv80 = 1'b1;
        @(posedge clk); #1;
        iv80 = 1'b0;
        iv128 = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!ov_s && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string nm, input bit w, input bit m, input logic [127:0] k,
                          input logic [63:0] d, input logic [63:0] e, input int lat_e, input bit hit_e);
        int lat;
        logic [63:0] x;
        send(w, m, k, d, e);
        n_chk++;
        if (hit_s !== hit_e) begin n_fail++; $display("FAIL %s cache_hit got %b want %b", nm, hit_s, hit_e); end
        n_chk++;
        if (busy_s !== 1'b1 || ir_s !== 1'b0) begin
            n_fail++; $display("FAIL %s busy/in_ready got %b/%b want 1/0", nm, busy_s, ir_s);
        end
        wait_out(lat);
        n_chk++;
        if (lat != lat_e) begin n_fail++; $display("FAIL %s latency got %0d want %0d", nm, lat, lat_e); end
        x = q_exp.pop_front();
        n_chk++;
        if (dout_s !== x) begin n_fail++; $display("FAIL %s dout got %h want %h", nm, dout_s, x); end
        take();
    endtask

    task automatic test_reset();
        n_chk++;
        if (ir80 !== 1'b1 || ov80 !== 1'b0 || dout80 !== 64'h0 || busy80 !== 1'b0 || hit80 !== 1'b0) begin
            n_fail++; $display("FAIL reset80 ir/ov/dout/busy/hit got %b/%b/%h/%b/%b want 1/0/0/0/0", ir80, ov80, dout80, busy80, hit80);
        end
        n_chk++;
        if (ir128 !== 1'b1 || ov128 !== 1'b0 || dout128 !== 64'h0 || busy128 !== 1'b0 || hit128 !== 1'b0) begin
            n_fail++; $display("FAIL reset128 ir/ov/dout/busy/hit got %b/%b/%h/%b/%b want 1/0/0/0/0", ir128, ov128, dout128, busy128, hit128);
        end
    endtask

    task automatic test_vectors();
        run_op("enc80_zero", 0, 0, 128'h0, 64'h0, 64'h5579C1387B228445, 32, 0);
        run_op("enc80_ones", 0, 0, K80F, ONES, 64'h3333DCD3213210D2, 32, 0);
        run_op("dec80_miss", 0, 1, K80F, 64'hE72C46C0F5945049, 64'h0, 63, 0);
        run_op("dec80_hit", 0, 1, K80F, 64'h3333DCD3213210D2, ONES, 32, 1);
        run_op("enc128_zero", 1, 0, 128'h0, 64'h0, 64'h96DB702A2E6900AF, 32, 0);
        run_op("dec128_miss", 1, 1, 128'h0, 64'h96DB702A2E6900AF, 64'h0, 63, 0);
        run_op("dec128_hit", 1, 1, 128'h0, 64'h96DB702A2E6900AF, 64'h0, 32, 1);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] x;
        send(0, 0, K80F, ONES, 64'h3333DCD3213210D2);
        wait_out(lat);
        n_chk++;
        if (lat != 32) begin n_fail++; $display("FAIL bp_latency got %0d want 32", lat); end
        x = q_exp.pop_front();
        for (int c = 0; c < 10; c++) begin
            n_chk++;
            if (ov_s !== 1'b1 || dout_s !== x || ir_s !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cycle %0d ov/dout/ir got %b/%h/%b want 1/%h/0", c, ov_s, dout_s, ir_s, x);
            end
            iv80 = (c == 4);
            mode = 1'b1;
            din = 64'h0123_4567_89AB_CDEF;
            @(posedge clk); #1;
        end
        iv80 = 1'b0;
        take();
        n_chk++;
        if (ov_s !== 1'b0 || ir_s !== 1'b1 || dout_s !== x) begin
            n_fail++; $display("FAIL bp_release ov/ir/dout got %b/%b/%h want 0/1/%h", ov_s, ir_s, dout_s, x);
        end
        // Consumer ready before the result appears: one-cycle handshake.
        out_ready = 1'b1;
        send(0, 0, 128'h0, 64'h0, 64'h5579C1387B228445);
        wait_out(lat);
        x = q_exp.pop_front();
        n_chk++;
        if (lat != 32 || dout_s !== x) begin
            n_fail++; $display("FAIL bp_early_ready lat/dout got %0d/%h want 32/%h", lat, dout_s, x);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_chk++;
        if (ov_s !== 1'b0 || ir_s !== 1'b1) begin
            n_fail++; $display("FAIL bp_one_cycle ov/ir got %b/%b want 0/1", ov_s, ir_s);
        end
    endtask

    task automatic test_busy_ignored();
        int lat = 0;
        int l2;
        logic [63:0] x;
        send(0, 0, 128'h0, 64'h0, 64'h5579C1387B228445);
        repeat (5) begin @(posedge clk); #1; lat++; end
        iv80 = 1'b1;
        mode = 1'b1;
        key = K80F;
        din = ONES;
        @(posedge clk); #1;
        lat++;
        iv80 = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        din = {$urandom, $urandom};
        wait_out(l2);
        lat += l2;
        n_chk++;
        if (lat != 32) begin n_fail++; $display("FAIL busy_ignore latency got %0d want 32", lat); end
        x = q_exp.pop_front();
        n_chk++;
        if (dout_s !== x) begin n_fail++; $display("FAIL busy_ignore dout got %h want %h", dout_s, x); end
        take();
        n_chk++;
        if (ir_s !== 1'b1 || busy_s !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignore idle ir/busy got %b/%b want 1/0", ir_s, busy_s);
        end
    endtask

    task automatic test_cache_persist();
        run_op("cache_after_enc", 0, 1, K80F, 64'hE72C46C0F5945049, 64'h0, 32, 1);
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        send(0, 0, 128'h0, 64'h0, 64'h5579C1387B228445);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_exp.delete();
        n_chk++;
        if (ir_s !== 1'b1 || busy_s !== 1'b0 || ov_s !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle ir/busy/ov got %b/%b/%b want 1/0/0", ir_s, busy_s, ov_s);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (ov_s) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL abort_no_output out_valid got 1 want 0"); end
        run_op("abort_cache_cleared", 0, 1, K80F, 64'h3333DCD3213210D2, ONES, 63, 0);
    endtask

    task automatic test_random();
        logic [127:0] k;
        logic [63:0] p, c;
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < 200; t++) begin
                k = {$urandom, $urandom, $urandom, $urandom};
                if (w == 0) k[127:80] = '0;
                p = {$urandom, $urandom};
                c = m_enc(w != 0, k, p);
                run_op("rnd_enc", w != 0, 0, k, p, c, 32, 0);
                run_op("rnd_dec", w != 0, 1, k, c, p, 63, 0);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_busy_ignored();
        test_cache_persist();
        test_abort();
        test_random();
        n_chk++;
        if (q_exp.size() != 0) begin n_fail++; $display("FAIL sb_drain entries got %0d want 0", q_exp.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
